// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator: one shared prescaler and period counter, per-channel duty.
// Period, mode and duties are double-buffered and applied only at a period boundary.
module pwm_multicanal #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic [WIDTH-1:0]          period_in,
    input  logic                      mode_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      load_pending
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESC_W-1:0]        presc_q, presc_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    dir_t                      dir_q, dir_d;
    logic                      mode_q, mode_d;
    logic [WIDTH-1:0]          per_q, per_d;
    logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
    logic                      sh_mode_q, sh_mode_d;
    logic [WIDTH-1:0]          sh_per_q, sh_per_d;
    logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic                      pend_q, pend_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      pe_q, pe_d;

    logic                      tick;
    logic                      boundary;
    logic [WIDTH-1:0]          cnt_inc;
    logic [WIDTH-1:0]          cnt_dec;

    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        per_d     = per_q;
        duty_d    = duty_q;
        sh_mode_d = sh_mode_q;
        sh_per_d  = sh_per_q;
        sh_duty_d = sh_duty_q;
        pend_d    = pend_q;
        pwm_d     = '0;
        boundary  = 1'b0;
        cnt_inc   = cnt_q + 1'b1;
        cnt_dec   = cnt_q - 1'b1;
        tick      = enable && (presc_q == prescale);

        // A prescale lowered below the current count lets the count wrap through all-ones.
        if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (tick) begin
            if (!mode_q) begin
                if (cnt_q == per_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (per_q == '0) begin
                cnt_d    = '0;
                dir_d    = DIR_UP;
                boundary = 1'b1;
            end else if (dir_q == DIR_UP) begin
                cnt_d = cnt_inc;
                if (cnt_inc == per_q) begin
                    dir_d = DIR_DOWN;
                end
            end else begin
                cnt_d = cnt_dec;
                if (cnt_dec == '0) begin
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end
            end
        end

        // Transfer uses the shadow as it stood before any load arriving this same cycle.
        if (boundary && pend_q) begin
            per_d  = sh_per_q;
            mode_d = sh_mode_q;
            duty_d = sh_duty_q;
            cnt_d  = '0;
            dir_d  = DIR_UP;
            pend_d = 1'b0;
        end

        if (duty_load) begin
            sh_per_d  = period_in;
            sh_mode_d = mode_in;
            sh_duty_d = duty_in;
            pend_d    = 1'b1;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (duty_q[i*WIDTH +: WIDTH] > cnt_q);
        end
        pe_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= 1'b0;
            per_q     <= '1;
            duty_q    <= '0;
            sh_mode_q <= 1'b0;
            sh_per_q  <= '1;
            sh_duty_q <= '0;
            pend_q    <= 1'b0;
            pwm_q     <= '0;
            pe_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            per_q     <= per_d;
            duty_q    <= duty_d;
            sh_mode_q <= sh_mode_d;
            sh_per_q  <= sh_per_d;
            sh_duty_q <= sh_duty_d;
            pend_q    <= pend_d;
            pwm_q     <= pwm_d;
            pe_q      <= pe_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_end   = pe_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Bench for pwm_multicanal: period-position reference model checked every cycle,
// a table of configurations measured over a full period, and hand-written corner sequences.
module tb_pwm_multicanal;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int PRESC_W  = 8;

    logic                      clk;
    logic                      reset;
    logic                      enable;
    logic [PRESC_W-1:0]        prescale;
    logic [WIDTH-1:0]          period_in;
    logic                      mode_in;
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic                      duty_load;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end;
    logic                      load_pending;

    pwm_multicanal #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .prescale(prescale),
        .period_in(period_in),
        .mode_in(mode_in),
        .duty_in(duty_in),
        .duty_load(duty_load),
        .pwm_out(pwm_out),
        .period_end(period_end),
        .load_pending(load_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chkOn = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: tracks the tick position inside the current period and derives
    // the counter value from it, rather than stepping an up/down counter.
    int               mPc, mPos, mP, mMode, sP, sMode, curCnt, len;
    int               mDuty[CHANNELS];
    int               sDuty[CHANNELS];
    bit               mPend, tk, bnd, expPe;
    logic [CHANNELS-1:0] expPwm, np;

    function automatic int periodLen(input int p, input int md);
        if (md == 0) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    function automatic int cntOf(input int pos, input int p, input int md);
        if (md == 0 || pos <= p) return pos;
        return 2 * p - pos;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mPc = 0; mPos = 0; mP = 255; mMode = 0; sP = 255; sMode = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                mDuty[c] = 0;
                sDuty[c] = 0;
            end
            mPend = 0; expPwm = '0; expPe = 0;
        end else begin
            tk = enable && (mPc == int'(prescale));
            if (enable) mPc = tk ? 0 : (mPc + 1) % 256;
            curCnt = cntOf(mPos, mP, mMode);
            for (int c = 0; c < CHANNELS; c++) np[c] = enable && (mDuty[c] > curCnt);
            bnd = 0;
            if (tk) begin
                len = periodLen(mP, mMode);
                mPos++;
                if (mPos >= len) begin
                    mPos = 0;
                    bnd  = 1;
                end
            end
            if (bnd && mPend) begin
                mP = sP; mMode = sMode;
                for (int c = 0; c < CHANNELS; c++) mDuty[c] = sDuty[c];
                mPend = 0;
            end
            if (duty_load) begin
                sP = int'(period_in); sMode = int'(mode_in);
                for (int c = 0; c < CHANNELS; c++) sDuty[c] = int'(duty_in[c*WIDTH +: WIDTH]);
                mPend = 1;
            end
            expPwm = np;
            expPe  = bnd;
        end
    end

    always @(negedge clk) begin
        if (chkOn) begin
            checkOutput("modelPwm", int'(pwm_out), int'(expPwm));
            checkOutput("modelPeriodEnd", int'(period_end), int'(expPe));
            checkOutput("modelPending", int'(load_pending), int'(mPend));
        end
    end

    typedef struct {
        int ps; int per; int mode; int d0; int d1;
        int len; int h0; int h1;
    } vec_t;

    vec_t vecs[6];

    task automatic waitPe();
        int n = 0;
        while (!period_end && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("periodEndTimeout", int'(period_end), 1);
    endtask

    // Loads a configuration and returns at the period_end of the first full period using it.
    task automatic applyStimulus(input int ps, input int per, input int md, input int d0, input int d1);
        int n = 0;
        prescale  = PRESC_W'(ps);
        period_in = WIDTH'(per);
        mode_in   = 1'(md);
        duty_in   = {WIDTH'(d1), WIDTH'(d0)};
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        while (load_pending && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("applyTimeout", int'(load_pending), 0);
        @(negedge clk);
        waitPe();
    endtask

    task automatic measurePeriod(output int l, output int h0, output int h1);
        l = 0; h0 = 0; h1 = 0;
        do begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            l++;
            @(negedge clk);
        end while (!period_end && l < 3000);
    endtask

    int n, l, h0, h1;

    initial begin
        vecs[0] = '{ps:0, per:9, mode:0, d0:3, d1:10, len:10, h0:3,  h1:10};
        vecs[1] = '{ps:1, per:4, mode:1, d0:2, d1:0,  len:16, h0:6,  h1:0};
        vecs[2] = '{ps:0, per:5, mode:1, d0:5, d1:6,  len:10, h0:9,  h1:10};
        vecs[3] = '{ps:2, per:7, mode:0, d0:0, d1:8,  len:24, h0:0,  h1:24};
        vecs[4] = '{ps:0, per:0, mode:0, d0:1, d1:0,  len:1,  h0:1,  h1:0};
        vecs[5] = '{ps:1, per:3, mode:0, d0:2, d1:3,  len:8,  h0:4,  h1:6};

        reset = 1'b0; enable = 1'b1; prescale = '0; period_in = '0;
        mode_in = 1'b0; duty_in = '0; duty_load = 1'b0;
        repeat (3) @(negedge clk);
        chkOn = 1'b1;
        checkOutput("resetPwm", int'(pwm_out), 0);
        checkOutput("resetPeriodEnd", int'(period_end), 0);
        checkOutput("resetPending", int'(load_pending), 0);

        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < 1000);
        checkOutput("firstPeriodCycles", n, 256);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].ps, vecs[i].per, vecs[i].mode, vecs[i].d0, vecs[i].d1);
            measurePeriod(l, h0, h1);
            checkOutput($sformatf("vec%0dLen", i), l, vecs[i].len);
            checkOutput($sformatf("vec%0dHigh0", i), h0, vecs[i].h0);
            checkOutput($sformatf("vec%0dHigh1", i), h1, vecs[i].h1);
        end

        // Mid-period load, then a second load landing exactly on the boundary edge.
        applyStimulus(0, 9, 0, 3, 10);
        repeat (3) @(negedge clk);
        duty_in = {8'd10, 8'd5}; duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        checkOutput("midLoadPending", int'(load_pending), 1);
        repeat (5) @(negedge clk);
        duty_in = {8'd10, 8'd7}; duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        checkOutput("coincPeriodEnd", int'(period_end), 1);
        checkOutput("coincPending", int'(load_pending), 1);
        measurePeriod(l, h0, h1);
        checkOutput("coincLen", l, 10);
        checkOutput("coincHigh0", h0, 5);
        checkOutput("afterCoincPending", int'(load_pending), 0);
        measurePeriod(l, h0, h1);
        checkOutput("lateHigh0", h0, 7);
        checkOutput("lateHigh1", h1, 10);

        // Enable gating mid-period: outputs forced low, counter frozen.
        repeat (4) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput("gatedPwm", int'(pwm_out), 0);
            checkOutput("gatedPeriodEnd", int'(period_end), 0);
        end
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < 100);
        checkOutput("resumeCycles", n, 6);

        // Reset during a centre-mode down-count with a load pending.
        applyStimulus(0, 4, 1, 2, 5);
        repeat (2) @(negedge clk);
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midResetPwm", int'(pwm_out), 0);
        checkOutput("midResetPeriodEnd", int'(period_end), 0);
        checkOutput("midResetPending", int'(load_pending), 0);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < 1000);
        checkOutput("postResetPeriodCycles", n, 256);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 499) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 199) == 0) prescale = PRESC_W'($urandom_range(0, 3));
            duty_load = ($urandom_range(0, 29) == 0);
            period_in = WIDTH'($urandom_range(0, 12));
            mode_in   = 1'($urandom_range(0, 1));
            duty_in   = {WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15))};
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
